// File: rtl/adc_spi_pkg.sv
// Shared definitions for the ADC SPI responder, the ADC sampler and their benches.
package adc_spi_pkg;

    localparam int unsigned ADC_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_WAIT_READ,
        ST_SHIFT,
        ST_DONE
    } adc_resp_state_t;

endpackage

// File: rtl/adc_spi_responder_sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous input followed by a one-flop edge detector.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI slave emulating the external 16-bit ADC: latches sample_i on conversion start and
// serves it MSB-first on MISO, entirely in the clk_i domain.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = ADC_DATA_WIDTH,
    parameter int unsigned CONV_CYCLES = 35,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic                  spi_clk_i,
    input  logic                  cnv_i,
    output logic                  spi_miso_o,
    output logic                  sample_ack_o,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  early_cnv_o
);

    localparam int unsigned CONV_W = $clog2(CONV_CYCLES + 1);
    localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);

    logic cnv_level, cnv_rise, cnv_fall;
    logic spi_level, spi_rise, spi_fall;
    logic shift_edge;

    adc_resp_state_t       state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CONV_W-1:0]     conv_cnt_q, conv_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  ack_q, ack_d;
    logic                  done_q, done_d;
    logic                  early_q, early_d;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_cnv_sync (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .async_i(cnv_i),
        .level_o(cnv_level),
        .rise_o (cnv_rise),
        .fall_o (cnv_fall)
    );

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_spi_clk_sync (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .async_i(spi_clk_i),
        .level_o(spi_level),
        .rise_o (spi_rise),
        .fall_o (spi_fall)
    );

    // A falling SPI clock only advances the frame while the frame select is held low.
    assign shift_edge = spi_fall && !spi_level && !cnv_level && !spi_rise;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            conv_cnt_q <= '0;
            bit_cnt_q  <= '0;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
            early_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            conv_cnt_q <= conv_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            early_q    <= early_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        conv_cnt_d = conv_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        ack_d      = 1'b0;
        done_d     = 1'b0;
        early_d    = 1'b0;

        // A conversion start pre-empts whatever the current state is doing.
        if (cnv_rise) begin
            shreg_d    = sample_i;
            ack_d      = 1'b1;
            conv_cnt_d = '0;
            state_d    = ST_CONVERT;
        end else begin
            unique case (state_q)
                ST_CONVERT: begin
                    if (cnv_fall) begin
                        early_d   = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_SHIFT;
                    end else if (conv_cnt_q == CONV_W'(CONV_CYCLES - 1)) begin
                        state_d = ST_WAIT_READ;
                    end else begin
                        conv_cnt_d = conv_cnt_q + 1'b1;
                    end
                end
                ST_WAIT_READ: begin
                    if (cnv_fall) begin
                        bit_cnt_d = '0;
                        state_d   = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (shift_edge) begin
                        shreg_d   = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign spi_miso_o   = (state_q == ST_SHIFT) ? shreg_q[DATA_WIDTH-1] : 1'b0;
    assign busy_o       = (state_q == ST_CONVERT);
    assign sample_ack_o = ack_q;
    assign frame_done_o = done_q;
    assign early_cnv_o  = early_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: a pin-level SPI master with a behavioural frame model checked every cycle.
module tb_adc_spi_responder;

    localparam int unsigned W = 16;
    localparam int unsigned C = 35;
    localparam int unsigned S = 2;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic [W-1:0] sample_i = '0;
    logic         spi_clk_i = 1'b0;
    logic         cnv_i = 1'b0;
    logic         spi_miso_o, sample_ack_o, busy_o, frame_done_o, early_cnv_o;

    always #10 clk_i = ~clk_i;

    adc_spi_responder #(
        .DATA_WIDTH (W),
        .CONV_CYCLES(C),
        .SYNC_STAGES(S)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .sample_i    (sample_i),
        .spi_clk_i   (spi_clk_i),
        .cnv_i       (cnv_i),
        .spi_miso_o  (spi_miso_o),
        .sample_ack_o(sample_ack_o),
        .busy_o      (busy_o),
        .frame_done_o(frame_done_o),
        .early_cnv_o (early_cnv_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pins are seen S+1 clocks late; a frame is a queue of bits still to send.
    typedef enum {M_IDLE, M_CONV, M_WAIT, M_SHIFT, M_DONE} mphase_t;
    mphase_t      m_phase = M_IDLE;
    bit           m_bits[$];
    int           m_elapsed = 0;
    logic [W-1:0] m_word = '0;
    logic [S+1:0] h_cnv = '0, h_spi = '0;
    bit           e_ack = 0, e_done = 0, e_early = 0, m_live = 0;

    always @(posedge clk_i) begin
        bit c_rise, c_fall, s_fall;
        e_ack = 0; e_done = 0; e_early = 0;
        if (reset_i) begin
            h_cnv = '0; h_spi = '0;
            m_phase = M_IDLE;
            m_bits.delete();
            m_live = 1;
        end else begin
            h_cnv = {h_cnv[S:0], cnv_i};
            h_spi = {h_spi[S:0], spi_clk_i};
            c_rise = h_cnv[S] && !h_cnv[S+1];
            c_fall = !h_cnv[S] && h_cnv[S+1];
            s_fall = !h_spi[S] && h_spi[S+1];
            if (c_rise) begin
                m_word = sample_i;
                m_phase = M_CONV;
                m_elapsed = 0;
                m_bits.delete();
                e_ack = 1;
            end else if (m_phase == M_CONV && c_fall) begin
                e_early = 1;
                m_phase = M_SHIFT;
                for (int i = W - 1; i >= 0; i--) m_bits.push_back(m_word[i]);
            end else if (m_phase == M_CONV) begin
                m_elapsed++;
                if (m_elapsed == C) m_phase = M_WAIT;
            end else if (m_phase == M_WAIT && c_fall) begin
                m_phase = M_SHIFT;
                for (int i = W - 1; i >= 0; i--) m_bits.push_back(m_word[i]);
            end else if (m_phase == M_SHIFT && s_fall) begin
                void'(m_bits.pop_front());
                if (m_bits.size() == 0) begin
                    m_phase = M_DONE;
                    e_done = 1;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (m_live) begin
            check("miso", spi_miso_o,
                  (m_phase == M_SHIFT && m_bits.size() > 0) ? m_bits[0] : 1'b0);
            check("busy", busy_o, m_phase == M_CONV);
            check("sample_ack", sample_ack_o, e_ack);
            check("frame_done", frame_done_o, e_done);
            check("early_cnv", early_cnv_o, e_early);
        end
    end

    int cnt_ack = 0, cnt_done = 0, cnt_early = 0;
    always @(negedge clk_i) begin
        if (sample_ack_o === 1'b1) cnt_ack++;
        if (frame_done_o === 1'b1) cnt_done++;
        if (early_cnv_o === 1'b1) cnt_early++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic start_conv(input logic [W-1:0] s, input int hold);
        sample_i = s;
        cnv_i = 1'b1;
        cyc(hold);
        sample_i = W'($urandom);
        cnv_i = 1'b0;
        cyc(S + 3);
    endtask

    task automatic pulses(input int n, input int half, output logic [W-1:0] got, output logic extra);
        got = '0;
        extra = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i < W) got = {got[W-2:0], spi_miso_o};
            else extra = extra | spi_miso_o;
            spi_clk_i = 1'b1;
            cyc(half);
            spi_clk_i = 1'b0;
            cyc(half);
        end
    endtask

    task automatic full_frame(input logic [W-1:0] s, input int hold, input string name);
        logic [W-1:0] got;
        logic         extra;
        int a0, d0, e0;
        a0 = cnt_ack; d0 = cnt_done; e0 = cnt_early;
        start_conv(s, hold);
        pulses(W, 4, got, extra);
        cyc(6);
        check({name, "_word"}, got, s);
        check({name, "_acks"}, cnt_ack - a0, 1);
        check({name, "_dones"}, cnt_done - d0, 1);
        check({name, "_early"}, cnt_early - e0, (hold < int'(C)) ? 1 : 0);
        check({name, "_miso_after"}, spi_miso_o, 1'b0);
    endtask

    initial begin
        logic [W-1:0] got;
        logic         extra;
        logic [W-1:0] words [4];
        int a0, d0;

        words[0] = 16'h8000; words[1] = 16'h7FFF; words[2] = 16'h0000; words[3] = 16'hFFFF;

        cyc(3);
        reset_i = 1'b0;
        cyc(1);
        check("rst_miso", spi_miso_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_ack", sample_ack_o, 1'b0);
        check("rst_done", frame_done_o, 1'b0);
        check("rst_early", early_cnv_o, 1'b0);

        full_frame(16'hA5C3, 45, "basic");
        foreach (words[i]) full_frame(words[i], 45, "b2b");

        full_frame(16'h3C96, 10, "early");

        a0 = cnt_ack; d0 = cnt_done;
        start_conv(16'h1234, 45);
        pulses(7, 4, got, extra);
        start_conv(16'hBEEF, 45);
        pulses(W, 4, got, extra);
        cyc(6);
        check("abort_word", got, 16'hBEEF);
        check("abort_acks", cnt_ack - a0, 2);
        check("abort_dones", cnt_done - d0, 1);

        d0 = cnt_done;
        start_conv(16'hC35A, 45);
        pulses(20, 4, got, extra);
        cyc(6);
        check("long_word", got, 16'hC35A);
        check("long_tail", extra, 1'b0);
        check("long_dones", cnt_done - d0, 1);

        start_conv(16'h5A5A, 45);
        pulses(5, 4, got, extra);
        reset_i = 1'b1;
        cyc(1);
        reset_i = 1'b0;
        check("midrst_miso", spi_miso_o, 1'b0);
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_pulses", {sample_ack_o, frame_done_o, early_cnv_o}, 3'b000);
        cyc(3);
        full_frame(16'h6B6B, 45, "postrst");

        for (int it = 0; it < 30; it++) begin
            logic [W-1:0] s;
            int hold, n, half;
            s = W'($urandom);
            hold = $urandom_range(3, 50);
            n = $urandom_range(10, 20);
            half = $urandom_range(4, 6);
            if ($urandom_range(0, 9) == 0) begin
                reset_i = 1'b1;
                cyc(1);
                reset_i = 1'b0;
                cyc(2);
            end
            start_conv(s, hold);
            pulses(n, half, got, extra);
            if (n >= int'(W)) check("rand_word", got, s);
            cyc($urandom_range(0, 5));
        end

        cyc(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
